// File: rtl/zjh_194_seq.sv
// zjh_194_seq: command sequencer driving a 74194-style universal shift register.
// Optional abort input enabled by defining ZJH_194_SEQ_ABORT_EN.
`default_nettype none

module zjh_194_seq (
  input  logic       Clk,
  input  logic       MR_N,
`ifdef ZJH_194_SEQ_ABORT_EN
  input  logic       Abort,
`endif
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [1:0] Cmd_Op,
  input  logic [2:0] Cmd_Cnt,
  input  logic [3:0] Cmd_Data,
  input  logic       Ser_In,
  input  logic [3:0] Reg_Q,
  output logic [1:0] Reg_S,
  output logic [1:0] Reg_D,
  output logic [3:0] Reg_In,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_RIGHT = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [2:0] r_cnt;
  logic [3:0] r_data;
  logic       w_xfer;
  logic       w_abort;
  logic       w_unused_q;

  // Only the last stage is needed, to close the loop for rotate.
  assign w_unused_q = ^Reg_Q[2:0];

`ifdef ZJH_194_SEQ_ABORT_EN
  assign w_abort = Abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_xfer = Cmd_Valid && (r_state == S_IDLE);

  always_ff @(posedge Clk or negedge MR_N) begin
    if (!MR_N) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_cnt   <= 3'd0;
      r_data  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_op   <= Cmd_Op;
        r_cnt  <= Cmd_Cnt;
        r_data <= Cmd_Data;
      end else if (r_state == S_SHIFT) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    Cmd_Ready = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    Reg_S     = 2'b00;
    Reg_D     = 2'b00;
    Reg_In    = 4'b0000;
    case (r_state)
      S_IDLE: begin
        Cmd_Ready = 1'b1;
        Busy      = 1'b0;
        if (w_xfer) begin
          w_next = (Cmd_Op == OP_LOAD) ? S_LOAD : S_SHIFT;
        end
      end
      S_LOAD: begin
        Reg_S  = 2'b11;
        Reg_In = r_data;
        w_next = S_DONE;
      end
      S_SHIFT: begin
        // The shift in the current cycle still happens even when aborting.
        case (r_op)
          OP_RIGHT: begin
            Reg_S = 2'b01;
            Reg_D = {1'b0, Ser_In};
          end
          OP_LEFT: begin
            Reg_S = 2'b10;
            Reg_D = {Ser_In, 1'b0};
          end
          OP_ROT: begin
            Reg_S = 2'b01;
            Reg_D = {1'b0, Reg_Q[3]};
          end
          default: begin
            Reg_S = 2'b00;
          end
        endcase
        if (r_cnt == 3'd0 || w_abort) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_zjh_194_seq.sv
// Testbench for zjh_194_seq with a behavioural 74194 model closing the Reg_Q loop.
`default_nettype none

module tb_zjh_194_seq;

  logic       Clk = 1'b0;
  logic       MR_N;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Op;
  logic [2:0] Cmd_Cnt;
  logic [3:0] Cmd_Data;
  logic       Ser_In;
  logic [3:0] Reg_Q;
  logic [1:0] Reg_S;
  logic [1:0] Reg_D;
  logic [3:0] Reg_In;
  logic       Busy;
  logic       Done;
`ifdef ZJH_194_SEQ_ABORT_EN
  logic       Abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  zjh_194_seq dut (
    .Clk       (Clk),
    .MR_N      (MR_N),
`ifdef ZJH_194_SEQ_ABORT_EN
    .Abort     (Abort),
`endif
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Ready (Cmd_Ready),
    .Cmd_Op    (Cmd_Op),
    .Cmd_Cnt   (Cmd_Cnt),
    .Cmd_Data  (Cmd_Data),
    .Ser_In    (Ser_In),
    .Reg_Q     (Reg_Q),
    .Reg_S     (Reg_S),
    .Reg_D     (Reg_D),
    .Reg_In    (Reg_In),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  // 74194 model: Reg_Q[0] is QA. Right shift enters at QA, left shift at QD.
  always @(posedge Clk or negedge MR_N) begin
    if (!MR_N) Reg_Q <= 4'b0000;
    else begin
      case (Reg_S)
        2'b01:   Reg_Q <= {Reg_Q[2:0], Reg_D[0]};
        2'b10:   Reg_Q <= {Reg_D[1], Reg_Q[3:1]};
        2'b11:   Reg_Q <= Reg_In;
        default: Reg_Q <= Reg_Q;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one command, then watches the op until Done (bounded).
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic ser, output int lat, output int n_mode, output int n_bad,
                         output int rdy_bad);
    logic [1:0] exp_s;
    logic [1:0] exp_d;
    logic [3:0] exp_in;
    lat = 0; n_mode = 0; n_bad = 0; rdy_bad = 0;
    exp_s = (op == 2'b00) ? 2'b11 : (op == 2'b10) ? 2'b10 : 2'b01;
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Cnt = cnt; Cmd_Data = data; Ser_In = ser;
    if (!Cmd_Ready) rdy_bad++;
    @(posedge Clk); #1;
    Cmd_Valid = 1'b0; Cmd_Op = ~op; Cmd_Cnt = ~cnt; Cmd_Data = ~data;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (Done) begin
        lat = k;
        if (Reg_S != 2'b00 || Reg_D != 2'b00 || Reg_In != 4'b0000) n_bad++;
        if (Cmd_Ready || !Busy) rdy_bad++;
        break;
      end
      if (Cmd_Ready || !Busy) rdy_bad++;
      exp_d  = (op == 2'b01) ? {1'b0, ser} : (op == 2'b10) ? {ser, 1'b0} :
               (op == 2'b11) ? {1'b0, Reg_Q[3]} : 2'b00;
      exp_in = (op == 2'b00) ? data : 4'b0000;
      if (Reg_S == exp_s) n_mode++;
      else n_bad++;
      if (Reg_D != exp_d || Reg_In != exp_in) n_bad++;
    end
    @(negedge Clk);
    if (Done || !Cmd_Ready || Busy) rdy_bad++;
  endtask

  typedef struct {
    logic [3:0] init;
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    logic       ser;
    logic [3:0] exp_q;
    int         exp_lat;
    int         exp_n;
  } vec_t;

  vec_t vecs[8];

  int lat, n_mode, n_bad, rdy_bad;
  int n_rdy, n_done, n_overlap;

  initial begin
    // Bit strings below are 4'b literals with Reg_Q[0] = QA on the right.
    vecs[0] = '{4'b0000, 2'b00, 3'd0, 4'b1010, 1'b0, 4'b1010, 2, 1};
    vecs[1] = '{4'b0001, 2'b01, 3'd1, 4'b0000, 1'b0, 4'b0100, 3, 2};
    vecs[2] = '{4'b0001, 2'b11, 3'd7, 4'b0000, 1'b0, 4'b0001, 9, 8};
    vecs[3] = '{4'b0000, 2'b10, 3'd0, 4'b0000, 1'b1, 4'b1000, 2, 1};
    vecs[4] = '{4'b1111, 2'b10, 3'd2, 4'b0000, 1'b0, 4'b0001, 4, 3};
    vecs[5] = '{4'b1000, 2'b11, 3'd0, 4'b0000, 1'b0, 4'b0001, 2, 1};
    vecs[6] = '{4'b0000, 2'b01, 3'd3, 4'b0000, 1'b1, 4'b1111, 5, 4};
    vecs[7] = '{4'b1001, 2'b11, 3'd1, 4'b0000, 1'b0, 4'b0110, 3, 2};

    MR_N = 1'b0; Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_Cnt = 3'd0; Cmd_Data = 4'd0; Ser_In = 1'b0;
`ifdef ZJH_194_SEQ_ABORT_EN
    Abort = 1'b0;
`endif
    #1;
    check("rst_ready", int'(Cmd_Ready), 1);
    check("rst_busy",  int'(Busy), 0);
    check("rst_done",  int'(Done), 0);
    check("rst_outs",  int'({Reg_S, Reg_D, Reg_In}), 0);
    repeat (2) @(negedge Clk);
    MR_N = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(2'b00, 3'd0, vecs[i].init, 1'b0, lat, n_mode, n_bad, rdy_bad);
      check($sformatf("v%0d_preload", i), int'(Reg_Q), int'(vecs[i].init));
      run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].ser, lat, n_mode, n_bad, rdy_bad);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_mode_cycles", i), n_mode, vecs[i].exp_n);
      check($sformatf("v%0d_bad_drive", i), n_bad, 0);
      check($sformatf("v%0d_ready_busy", i), rdy_bad, 0);
      check($sformatf("v%0d_reg_q", i), int'(Reg_Q), int'(vecs[i].exp_q));
    end

    // Valid held high: shift cnt 1 occupies 4 cycles, so 12 cycles give 3 transfers.
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b01; Cmd_Cnt = 3'd1; Ser_In = 1'b0;
    n_rdy = 0; n_done = 0; n_overlap = 0;
    for (int k = 0; k < 12; k++) begin
      if (Cmd_Ready) n_rdy++;
      if (Done) n_done++;
      if (Cmd_Ready && Busy) n_overlap++;
      @(negedge Clk);
    end
    Cmd_Valid = 1'b0;
    check("hold_ready_cycles", n_rdy, 3);
    check("hold_done_pulses", n_done, 3);
    check("hold_ready_busy", n_overlap, 0);
    @(negedge Clk);
    check("hold_idle_after", int'(Busy), 0);

    // Reset in SHIFT cycle 2 of an 8-shift rotate.
    run_cmd(2'b00, 3'd0, 4'b0001, 1'b0, lat, n_mode, n_bad, rdy_bad);
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b11; Cmd_Cnt = 3'd7;
    @(posedge Clk); #1;
    Cmd_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rstmid_in_shift", int'(Reg_S), 1);
    MR_N = 1'b0;
    #1;
    check("rstmid_busy", int'(Busy), 0);
    check("rstmid_reg_s", int'(Reg_S), 0);
    check("rstmid_ready", int'(Cmd_Ready), 1);
    check("rstmid_reg_q", int'(Reg_Q), 0);
    @(negedge Clk);
    MR_N = 1'b1;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (Done || Busy) n_done++;
    end
    check("rstmid_no_done", n_done, 0);

`ifdef ZJH_194_SEQ_ABORT_EN
    // Abort raised in SHIFT cycle 3 of an 8-shift right shift.
    run_cmd(2'b00, 3'd0, 4'b0001, 1'b0, lat, n_mode, n_bad, rdy_bad);
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b01; Cmd_Cnt = 3'd7; Ser_In = 1'b0;
    @(posedge Clk); #1;
    Cmd_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort_done", int'(Done), 1);
    check("abort_reg_q", int'(Reg_Q), int'(4'b1000));
    @(negedge Clk);
    check("abort_idle", int'(Busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/zjh_194_seq.md
ZJH_194_SEQ -- requirements
Module: zjh_194_seq

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port MR_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port Cmd_Valid, input, 1 bit: command request.
REQ-004 SHALL have port Cmd_Ready, output, 1 bit: controller accepts a command.
REQ-005 SHALL have port Cmd_Op, input, 2 bits: 00 load, 01 shift right, 10 shift left, 11 rotate right.
REQ-006 SHALL have port Cmd_Cnt, input, 3 bits: shift count minus 1, giving 1..8 shifts.
REQ-007 SHALL have port Cmd_Data, input, 4 bits: parallel load word.
REQ-008 SHALL have port Ser_In, input, 1 bit: fill bit for shift right and shift left.
REQ-009 SHALL have port Reg_Q, input, 4 bits: shift-register outputs, fed back.
REQ-010 SHALL have port Reg_S, output, 2 bits: mode to the shift register (00 hold, 01 right, 10 left, 11 load).
REQ-011 SHALL have port Reg_D, output, 2 bits: [0] right serial in, [1] left serial in.
REQ-012 SHALL have port Reg_In, output, 4 bits: parallel data to the shift register.
REQ-013 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT and DONE.
REQ-016 SHALL drive Cmd_Ready = 1 only in IDLE; a transfer occurs on a rising edge with Cmd_Valid & Cmd_Ready.
REQ-017 SHALL latch Cmd_Op, Cmd_Cnt and Cmd_Data on transfer; later input changes have no effect until the next transfer.
REQ-018 SHALL move from IDLE to LOAD on transfer with Op 00, and to SHIFT on any other Op; with no transfer it stays in IDLE.
REQ-019 SHALL decode Reg_S, Reg_D and Reg_In combinationally from state and latched command, so the shift register acts on the edge that ends each state.
REQ-020 In LOAD, SHALL drive Reg_S = 11 and Reg_In = latched data for exactly one cycle, then go to DONE.
REQ-021 In SHIFT, SHALL drive Reg_S = 01 for Op 01 and Op 11, and Reg_S = 10 for Op 10.
REQ-022 SHALL drive Reg_D[0] = Ser_In for Op 01, Reg_D[1] = Ser_In for Op 10, and Reg_D[0] = Reg_Q[3] for Op 11 (rotate); the unused Reg_D bit SHALL be 0.
REQ-023 SHALL use a 3-bit down-counter loaded with Cmd_Cnt on transfer, decremented each SHIFT cycle; SHIFT exits to DONE on the cycle the counter equals 0, giving exactly Cmd_Cnt+1 SHIFT cycles.
REQ-024 In IDLE and DONE, SHALL drive Reg_S = 00, Reg_D = 00 and Reg_In = 0000.
REQ-025 In DONE, SHALL assert Done for one cycle, then return to IDLE; the next command can therefore be accepted no earlier than 1 cycle after Done.
REQ-026 Cmd_Valid asserted outside IDLE SHALL be ignored and not queued; the requester holds it until Cmd_Ready.
REQ-027 Latency from transfer edge to Done high SHALL be 2 cycles for load and Cmd_Cnt+2 cycles for shift or rotate.

Reset
REQ-028 While MR_N = 0, SHALL force state IDLE, counter 0 and latched command 0.
REQ-029 While MR_N = 0, outputs SHALL be: Reg_S = 00, Reg_D = 00, Reg_In = 0000, Busy = 0, Done = 0, Cmd_Ready = 1.
REQ-030 MR_N falling mid-operation SHALL abort immediately with no Done pulse; the shift register is cleared by the same MR_N.

Configuration
REQ-031 When macro ZJH_194_SEQ_ABORT_EN is defined, SHALL add input Abort (1 bit); Abort = 1 in LOAD or SHIFT SHALL force DONE on the next edge, so the remaining shifts are skipped and Done still pulses.
REQ-032 When ZJH_194_SEQ_ABORT_EN is undefined, the Abort port and its logic SHALL be absent, and behaviour SHALL be exactly REQ-015..REQ-030.

Verification
REQ-033 Bench SHALL cover: Load 1010 -> Reg_S = 11 for 1 cycle, Reg_Q = 1010, Done 2 cycles after transfer.
REQ-034 Bench SHALL cover: Reg_Q = 1000, shift right with Cnt 1 and Ser_In 0 -> 2 cycles of Reg_S = 01, Reg_Q = 0010, Done at cycle 3.
REQ-035 Bench SHALL cover: Reg_Q = 0001, rotate with Cnt 7 -> 8 SHIFT cycles, Reg_Q returns to 0001, Done at cycle 9.
REQ-036 Bench SHALL cover: Cmd_Valid held high through busy -> exactly one transfer per IDLE visit, with Cmd_Ready low for the whole op.
REQ-037 Bench SHALL cover: MR_N pulsed low in SHIFT cycle 2 -> IDLE, Busy 0, Reg_S 00, no Done pulse.
REQ-038 Bench SHALL cover, with ZJH_194_SEQ_ABORT_EN defined: Abort in SHIFT cycle 3 of an 8-shift op -> Done next cycle and exactly 3 shifts applied.
